synch_fifo_param: RTL and testbench

Parametrised single-clock FIFO and the next generation of the team's synchronous FIFO. It generalises data width and depth and adds programmable almost-full/almost-empty flags, an occupancy count, sticky overflow/underflow error flags, and a selectable first-word-fall-through (FWFT) read mode. It drops into the existing intf_fifo-style harness alongside the current FIFOs for comparative checking by the scoreboard.

---
 rtl/synch_fifo_param.sv | 79 +++++++
 tb/tb_synch_fifo_param.sv | 112 +++++++++++
 2 files changed

// File: rtl/synch_fifo_param.sv
// synch_fifo_param: parametrised single-clock FIFO with programmable almost flags,
// occupancy count, sticky overflow/underflow and optional first-word-fall-through read.
module synch_fifo_param #(
   parameter int DATA_W    = 8,
   parameter int DEPTH     = 16,
   parameter int AF_THRESH = DEPTH - 4,
   parameter int AE_THRESH = 2,
   parameter int FWFT      = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [DATA_W-1:0]          din,
   input  logic                       we,
   input  logic                       re,
   input  logic                       err_clr,
   output logic [DATA_W-1:0]          dout,
   output logic                       flagf,
   output logic                       flage,
   output logic                       flagaf,
   output logic                       flagae,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       ovf,
   output logic                       udf
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C   = CW'(AF_THRESH);
   localparam logic [CW-1:0] AE_C   = CW'(AE_THRESH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              ovf_q, ovf_d, udf_q, udf_d, rd_ok, wr_ok;

   assign flagf  = count_q == FULL_C;
   assign flage  = count_q == '0;
   assign flagaf = count_q >= AF_C;
   assign flagae = count_q <= AE_C;
   assign count  = count_q;
   assign ovf    = ovf_q;
   assign udf    = udf_q;
   // FWFT shows the head slot directly; otherwise dout is the word captured on the last accepted read
   assign dout   = (FWFT != 0) ? mem[rd_ptr_q] : dout_q;

   always_comb begin
      rd_ok    = re && !flage;
      wr_ok    = we && (!flagf || rd_ok);
      wr_ptr_d = wr_ptr_q + AW'(wr_ok);
      rd_ptr_d = rd_ptr_q + AW'(rd_ok);
      count_d  = count_q + CW'(wr_ok) - CW'(rd_ok);
      ovf_d    = (we && flagf && !rd_ok) || (ovf_q && !err_clr);
      udf_d    = (re && flage) || (udf_q && !err_clr);
      dout_d   = rd_ok ? mem[rd_ptr_q] : dout_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         dout_q   <= '0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         dout_q   <= dout_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr_q] <= din;
   end
endmodule

// File: tb/tb_synch_fifo_param.sv
// tb_synch_fifo_param: drives a registered-read and an FWFT instance with identical
// stimulus and checks both against a queue-based reference model.
module tb_synch_fifo_param;
   localparam int DW = 8;
   localparam int DP = 16;

   logic          clk = 1'b0, rst = 1'b1, we = 1'b0, re = 1'b0, err_clr = 1'b0;
   logic [DW-1:0] din = '0;
   logic [DW-1:0] dout0, dout1;
   logic [4:0]    cnt0, cnt1;
   logic          f0, e0, af0, ae0, ovf0, udf0;
   logic          f1, e1, af1, ae1, ovf1, udf1;
   int            checks = 0, failures = 0;
   logic [DW-1:0] q[$];
   logic [DW-1:0] m_dout = '0;
   logic          m_ovf = 1'b0, m_udf = 1'b0;

   always #5 clk = ~clk;

   synch_fifo_param #(.DATA_W(DW), .DEPTH(DP), .FWFT(0)) u0 (
      .clk(clk), .rst(rst), .din(din), .we(we), .re(re), .err_clr(err_clr),
      .dout(dout0), .flagf(f0), .flage(e0), .flagaf(af0), .flagae(ae0),
      .count(cnt0), .ovf(ovf0), .udf(udf0));

   synch_fifo_param #(.DATA_W(DW), .DEPTH(DP), .FWFT(1)) u1 (
      .clk(clk), .rst(rst), .din(din), .we(we), .re(re), .err_clr(err_clr),
      .dout(dout1), .flagf(f1), .flage(e1), .flagaf(af1), .flagae(ae1),
      .count(cnt1), .ovf(ovf1), .udf(udf1));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // {count, full, empty, almost_full, almost_empty, ovf, udf}
   function automatic logic [10:0] m_st();
      int n = q.size();
      return {5'(n), n == DP, n == 0, n >= DP - 4, n <= 2, m_ovf, m_udf};
   endfunction

   task automatic check_all();
      chk("status_reg", 32'({cnt0, f0, e0, af0, ae0, ovf0, udf0}), 32'(m_st()));
      chk("status_fwft", 32'({cnt1, f1, e1, af1, ae1, ovf1, udf1}), 32'(m_st()));
      chk("dout_reg", 32'(dout0), 32'(m_dout));
      if (q.size() > 0) chk("dout_fwft", 32'(dout1), 32'(q[0]));
   endtask

   task automatic cyc(input logic w, input logic r, input logic [DW-1:0] d, input logic c);
      bit rd_ok, wr_ok;
      we = w; re = r; din = d; err_clr = c;
      @(posedge clk);
      rd_ok = r && q.size() > 0;
      wr_ok = w && (q.size() < DP || rd_ok);
      m_ovf = (w && q.size() == DP && !rd_ok) || (m_ovf && !c);
      m_udf = (r && q.size() == 0) || (m_udf && !c);
      if (rd_ok) m_dout = q.pop_front();
      if (wr_ok) q.push_back(d);
      #1 check_all();
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (5) cyc(0, 0, 0, 0);
      for (int i = 1; i <= 16; i++) cyc(1, 0, 8'(i), 0);
      cyc(1, 0, 8'hFF, 0);
      repeat (16) cyc(0, 1, 0, 0);
      cyc(0, 0, 0, 1);
      repeat (2) begin
         repeat (10) cyc(1, 0, 8'($urandom), 0);
         repeat (10) cyc(0, 1, 0, 0);
      end
      repeat (16) cyc(1, 0, 8'($urandom), 0);
      cyc(1, 1, 8'hAA, 0);
      repeat (16) cyc(0, 1, 0, 0);
      chk("full_rw_last", 32'(dout0), 32'h0000_00AA);
      cyc(0, 1, 0, 0);
      cyc(0, 0, 0, 1);
      cyc(0, 1, 0, 1);
      chk("udf_err_wins", 32'(udf0), 32'd1);
      cyc(0, 0, 0, 1);
      for (int k = 0; k < 6; k++) begin
         int wp = (k % 2 == 0) ? 75 : 25;
         repeat (80) cyc($urandom_range(0, 99) < wp, $urandom_range(0, 99) < 100 - wp,
                         8'($urandom), $urandom_range(0, 19) == 0);
      end
      while (q.size() > 0) cyc(0, 1, 0, 0);
      cyc(0, 0, 0, 1);
      cyc(1, 0, 8'h5A, 0);
      chk("fwft_show", 32'({e1, dout1}), 32'h0000_005A);
      cyc(0, 1, 0, 0);
      chk("fwft_pop", 32'(e1), 32'd1);
      repeat (7) cyc(1, 0, 8'($urandom), 0);
      cyc(1, 0, 8'hFF, 0);
      #2 rst = 1'b1;
      #1;
      q.delete();
      m_dout = '0; m_ovf = 1'b0; m_udf = 1'b0;
      check_all();
      we = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (2) cyc(0, 0, 0, 0);
      repeat (3) cyc(1, 0, 8'($urandom), 0);
      repeat (4) cyc(0, 1, 0, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
